// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage scheduler: FSM state encoding,
// default butterfly latency, memory read latency and complex {re,im} helpers.
package fft_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} sched_state_t;

  localparam int BF_LATENCY_DEF = 3;
  localparam int MEM_RD_LAT     = 1;
  localparam int CPX_MAX_W      = 32;

  function automatic logic [2*CPX_MAX_W-1:0] cpx_mask(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [CPX_MAX_W-1:0] cpx_re(input logic [2*CPX_MAX_W-1:0] z,
                                                  input int unsigned w);
    return CPX_MAX_W'((z >> w) & cpx_mask(w));
  endfunction

  function automatic logic [CPX_MAX_W-1:0] cpx_im(input logic [2*CPX_MAX_W-1:0] z,
                                                  input int unsigned w);
    return CPX_MAX_W'(z & cpx_mask(w));
  endfunction

  function automatic logic [2*CPX_MAX_W-1:0] cpx_pack(input logic [CPX_MAX_W-1:0] re,
                                                      input logic [CPX_MAX_W-1:0] im,
                                                      input int unsigned w);
    return ((64'(re) & cpx_mask(w)) << w) | (64'(im) & cpx_mask(w));
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT in-place address generator: (stage, butterfly j) -> operand
// pair addresses and twiddle ROM index. Purely combinational.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = 10,
  parameter int SW    = 4
) (
  input  logic [SW-1:0]    stage,
  input  logic [LOG2N-2:0] j,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_addr
);
  localparam int AW = LOG2N;

  logic [AW-1:0] jx, half, k;

  assign jx   = {1'b0, j};
  assign half = AW'(1) << stage;
  assign k    = jx & (half - AW'(1));

  // Insert a zero at bit position 'stage' of j to get the A index; B sets it.
  assign addr_a  = ((jx >> stage) << (int'(stage) + 1)) | k;
  assign addr_b  = addr_a | half;
  assign tw_addr = k[AW-2:0] << (LOG2N - 1 - int'(stage));

endmodule

// File: rtl/fft_stage_scheduler.sv
// In-place radix-2 DIT FFT sequencer: walks all stages, issues RAM/ROM reads
// to the butterfly and writes results back. FFT_SCHED_INVERSE_EN adds i_inverse.
module fft_stage_scheduler
  import fft_pkg::*;
#(
  parameter  int FFT_LENGTH    = 1024,
  parameter  int DATA_WIDTH    = 24,
  parameter  int TWIDDLE_WIDTH = 24,
  parameter  int BF_LATENCY    = BF_LATENCY_DEF,
  localparam int LOG2N         = $clog2(FFT_LENGTH),
  localparam int ADDR_WIDTH    = LOG2N,
  localparam int TW_ADDR_WIDTH = LOG2N - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_start,
`ifdef FFT_SCHED_INVERSE_EN
  input  logic                       i_inverse,
`endif
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error,
  output logic                       o_rd_en,
  output logic [ADDR_WIDTH-1:0]      o_rd_addr_a,
  output logic [ADDR_WIDTH-1:0]      o_rd_addr_b,
  input  logic [2*DATA_WIDTH-1:0]    i_rd_data_a,
  input  logic [2*DATA_WIDTH-1:0]    i_rd_data_b,
  output logic [TW_ADDR_WIDTH-1:0]   o_tw_addr,
  input  logic [2*TWIDDLE_WIDTH-1:0] i_tw_data,
  output logic                       o_bf_start,
  output logic [2*DATA_WIDTH-1:0]    o_bf_a,
  output logic [2*DATA_WIDTH-1:0]    o_bf_b,
  output logic [2*TWIDDLE_WIDTH-1:0] o_bf_twiddle,
  input  logic                       i_bf_valid,
  input  logic [2*DATA_WIDTH-1:0]    i_bf_a,
  input  logic [2*DATA_WIDTH-1:0]    i_bf_b,
  output logic                       o_wr_en,
  output logic [ADDR_WIDTH-1:0]      o_wr_addr_a,
  output logic [ADDR_WIDTH-1:0]      o_wr_addr_b,
  output logic [2*DATA_WIDTH-1:0]    o_wr_data_a,
  output logic [2*DATA_WIDTH-1:0]    o_wr_data_b
);
  localparam int STAGES = MEM_RD_LAT + BF_LATENCY - 1;
  localparam int SW     = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int JW     = LOG2N - 1;
  localparam int CW     = $clog2(BF_LATENCY + 3) + 1;
  localparam int QW     = $clog2(BF_LATENCY + 2);
  localparam logic [JW-1:0] J_LAST = JW'(FFT_LENGTH/2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

  sched_state_t state;
  logic [SW-1:0] stage, nxt_stage;
  logic [JW-1:0] j, nxt_j;
  logic          launch, accept, wr_en, err_evt;
  logic [CW-1:0] inflight, inflight_nxt;
  logic [QW-1:0] quiet;

  logic [ADDR_WIDTH-1:0]    gen_a, gen_b;
  logic [TW_ADDR_WIDTH-1:0] gen_tw;

  logic [STAGES:0]                 vld_pipe;
  logic [STAGES:0][ADDR_WIDTH-1:0] tag_a, tag_b;

  assign accept       = (state == S_IDLE) && i_start;
  assign wr_en        = i_bf_valid && vld_pipe[STAGES] && (inflight != '0);
  // Results still leaving the butterfly right after a reset are not errors.
  assign err_evt      = i_bf_valid && !wr_en && (quiet == '0);
  assign inflight_nxt = inflight + CW'(o_rd_en) - CW'(wr_en);

  always_comb begin
    launch    = 1'b0;
    nxt_stage = stage;
    nxt_j     = j;
    case (state)
      S_IDLE: if (i_start) begin
        launch    = 1'b1;
        nxt_stage = '0;
        nxt_j     = '0;
      end
      S_ISSUE: if (j != J_LAST) begin
        launch = 1'b1;
        nxt_j  = j + JW'(1);
      end
      S_DRAIN: if (inflight_nxt == '0 && stage != S_LAST) begin
        launch    = 1'b1;
        nxt_stage = stage + SW'(1);
        nxt_j     = '0;
      end
      default: ;
    endcase
  end

  fft_addr_gen #(.LOG2N(LOG2N), .SW(SW)) u_addr_gen (
    .stage   (nxt_stage),
    .j       (nxt_j),
    .addr_a  (gen_a),
    .addr_b  (gen_b),
    .tw_addr (gen_tw)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      stage       <= '0;
      j           <= '0;
      o_rd_en     <= 1'b0;
      o_rd_addr_a <= '0;
      o_rd_addr_b <= '0;
      o_tw_addr   <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      inflight    <= '0;
      quiet       <= QW'(BF_LATENCY + 1);
    end else begin
      stage       <= nxt_stage;
      j           <= nxt_j;
      o_rd_en     <= launch;
      o_rd_addr_a <= launch ? gen_a  : '0;
      o_rd_addr_b <= launch ? gen_b  : '0;
      o_tw_addr   <= launch ? gen_tw : '0;
      inflight    <= inflight_nxt;
      o_done      <= 1'b0;
      o_error     <= (o_error && !accept) || err_evt;
      if (quiet != '0) quiet <= quiet - QW'(1);
      case (state)
        S_IDLE: if (i_start) begin
          state  <= S_ISSUE;
          o_busy <= 1'b1;
        end
        S_ISSUE: if (j == J_LAST) state <= S_DRAIN;
        S_DRAIN: if (inflight_nxt == '0) begin
          if (stage == S_LAST) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            state  <= S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write-address tag line: each read's addresses ride along until its result returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      tag_a    <= '0;
      tag_b    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], o_rd_en};
      tag_a    <= {tag_a[STAGES-1:0], o_rd_addr_a};
      tag_b    <= {tag_b[STAGES-1:0], o_rd_addr_b};
    end
  end

  assign o_bf_start = vld_pipe[MEM_RD_LAT-1];
  assign o_bf_a     = o_bf_start ? i_rd_data_a : '0;
  assign o_bf_b     = o_bf_start ? i_rd_data_b : '0;

`ifdef FFT_SCHED_INVERSE_EN
  logic                          inv_q;
  logic [CPX_MAX_W-1:0]          tw_re, tw_im, tw_im_sel;
  logic [2*CPX_MAX_W-1:0]        tw_pk;

  always_ff @(posedge clk) begin
    if (reset)       inv_q <= 1'b0;
    else if (accept) inv_q <= i_inverse;
  end

  assign tw_re        = cpx_re(64'(i_tw_data), TWIDDLE_WIDTH);
  assign tw_im        = cpx_im(64'(i_tw_data), TWIDDLE_WIDTH);
  assign tw_im_sel    = inv_q ? -tw_im : tw_im;
  assign tw_pk        = cpx_pack(tw_re, tw_im_sel, TWIDDLE_WIDTH);
  assign o_bf_twiddle = o_bf_start ? tw_pk[2*TWIDDLE_WIDTH-1:0] : '0;
`else
  assign o_bf_twiddle = o_bf_start ? i_tw_data : '0;
`endif

  assign o_wr_en     = wr_en;
  assign o_wr_addr_a = wr_en ? tag_a[STAGES] : '0;
  assign o_wr_addr_b = wr_en ? tag_b[STAGES] : '0;
  assign o_wr_data_a = wr_en ? i_bf_a : '0;
  assign o_wr_data_b = wr_en ? i_bf_b : '0;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Directed bench for fft_stage_scheduler at N=8, BF_LATENCY=3 with a
// behavioural sample RAM, twiddle ROM and scaled radix-2 butterfly.
module tb_fft_stage_scheduler;
  localparam int N  = 8;
  localparam int DW = 24;
  localparam int TW = 24;
  localparam int L  = 3;

  logic clk = 1'b0;
  logic reset, i_start, ld, inj;
`ifdef FFT_SCHED_INVERSE_EN
  logic i_inverse;
`endif
  logic o_busy, o_done, o_error, o_rd_en, o_bf_start, i_bf_valid, o_wr_en;
  logic [2:0] o_rd_addr_a, o_rd_addr_b, o_wr_addr_a, o_wr_addr_b;
  logic [1:0] o_tw_addr;
  logic [2*DW-1:0] rd_a, rd_b, o_bf_a, o_bf_b, i_bf_a, i_bf_b, o_wr_data_a, o_wr_data_b;
  logic [2*TW-1:0] tw_q, o_bf_twiddle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_stage_scheduler #(
    .FFT_LENGTH(N), .DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW), .BF_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start),
`ifdef FFT_SCHED_INVERSE_EN
    .i_inverse(i_inverse),
`endif
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_rd_en(o_rd_en), .o_rd_addr_a(o_rd_addr_a), .o_rd_addr_b(o_rd_addr_b),
    .i_rd_data_a(rd_a), .i_rd_data_b(rd_b),
    .o_tw_addr(o_tw_addr), .i_tw_data(tw_q),
    .o_bf_start(o_bf_start), .o_bf_a(o_bf_a), .o_bf_b(o_bf_b), .o_bf_twiddle(o_bf_twiddle),
    .i_bf_valid(i_bf_valid), .i_bf_a(i_bf_a), .i_bf_b(i_bf_b),
    .o_wr_en(o_wr_en), .o_wr_addr_a(o_wr_addr_a), .o_wr_addr_b(o_wr_addr_b),
    .o_wr_data_a(o_wr_data_a), .o_wr_data_b(o_wr_data_b)
  );

  // Entry 2 carries a distinctive value so the twiddle path is observable.
  function automatic logic [2*TW-1:0] rom_f(input logic [1:0] a);
    case (a)
      2'd0:    return 48'h7FFFFF_000000;
      2'd1:    return 48'h5A827A_A57D86;
      2'd2:    return 48'h000000_C00000;
      default: return 48'hA57D86_A57D86;
    endcase
  endfunction

  // Scaled DIT butterfly: A' = (A + W*B)/2, B' = (A - W*B)/2, W in Q1.23.
  function automatic logic [95:0] bfly(input logic [47:0] a, input logic [47:0] b,
                                       input logic [47:0] w);
    logic signed [23:0] ar, ai, br, bi, wr, wi;
    logic signed [47:0] mr, mi;
    logic signed [25:0] xr, xi, sr, si, dr, di;
    {ar, ai} = a;
    {br, bi} = b;
    {wr, wi} = w;
    mr = 48'(wr) * 48'(br) - 48'(wi) * 48'(bi);
    mi = 48'(wr) * 48'(bi) + 48'(wi) * 48'(br);
    xr = 26'(mr >>> 23);
    xi = 26'(mi >>> 23);
    sr = 26'(ar) + xr;
    si = 26'(ai) + xi;
    dr = 26'(ar) - xr;
    di = 26'(ai) - xi;
    return {24'(sr >>> 1), 24'(si >>> 1), 24'(dr >>> 1), 24'(di >>> 1)};
  endfunction

  logic [2*DW-1:0] mem [N];
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < N; i++) mem[i] <= (i == 0) ? 48'h100000_000000 : 48'h0;
    end else if (o_wr_en) begin
      mem[o_wr_addr_a] <= o_wr_data_a;
      mem[o_wr_addr_b] <= o_wr_data_b;
    end
    if (o_rd_en) begin
      rd_a <= mem[o_rd_addr_a];
      rd_b <= mem[o_rd_addr_b];
    end
    tw_q <= rom_f(o_tw_addr);
  end

  logic [2:0]  bv = '0;
  logic [95:0] bd [3];
  always @(posedge clk) begin
    bv    <= {bv[1:0], o_bf_start};
    bd[0] <= bfly(o_bf_a, o_bf_b, o_bf_twiddle);
    bd[1] <= bd[0];
    bd[2] <= bd[1];
  end
  assign i_bf_valid = bv[2] | inj;
  assign i_bf_a     = bd[2][95:48];
  assign i_bf_b     = bd[2][47:0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a transform at cycle 0; stop at o_done, at cycle stop_at, or after a bound.
  task automatic run(input bit probe, input int stop_at, output int done_at);
    int n;
    done_at = -1;
    n = 0;
    i_start = 1'b1;
    while (n < 60) begin
      tick();
      n++;
      i_start = probe && (n == 2 || n == 6);
      if (probe) begin
        case (n)
          1:  chk("rd_first", 64'({o_rd_en, o_busy, o_rd_addr_a, o_rd_addr_b}), 64'({2'b11, 3'd0, 3'd1}));
          2:  chk("bf_a_first", 64'(o_bf_a), 64'h100000_000000);
          4:  chk("addr_s0j3", 64'({o_rd_addr_a, o_rd_addr_b, o_tw_addr}), 64'({3'd6, 3'd7, 2'd0}));
          5:  chk("tw_s0", 64'(o_bf_twiddle), 64'h7FFFFF_000000);
          8:  chk("wr_s0j3", 64'({o_wr_en, o_wr_addr_a, o_wr_addr_b}), 64'({1'b1, 3'd6, 3'd7}));
          9:  chk("s1_first_rd", 64'({o_rd_en, o_wr_en, o_rd_addr_a, o_rd_addr_b}), 64'({2'b10, 3'd0, 3'd2}));
          12: chk("addr_s1j3", 64'({o_rd_addr_a, o_rd_addr_b, o_tw_addr}), 64'({3'd5, 3'd7, 2'd2}));
          13: chk("tw_s1", 64'(o_bf_twiddle), 64'h000000_C00000);
          20: chk("addr_s2j3", 64'({o_rd_addr_a, o_rd_addr_b, o_tw_addr}), 64'({3'd3, 3'd7, 2'd3}));
          default: ;
        endcase
      end
      if (o_done) begin
        done_at = n;
        break;
      end
      if (n == stop_at) break;
    end
    i_start = 1'b0;
  endtask

  initial begin
    int d;
    logic wr_seen, err_seen;
    reset = 1'b1; i_start = 1'b0; ld = 1'b0; inj = 1'b0;
`ifdef FFT_SCHED_INVERSE_EN
    i_inverse = 1'b0;
`endif
    tick(); tick();
    chk("reset_flags", 64'({o_busy, o_done, o_error, o_rd_en, o_bf_start, o_wr_en}), 64'd0);
    chk("reset_addrs", 64'({o_rd_addr_a, o_rd_addr_b, o_tw_addr, o_wr_addr_a, o_wr_addr_b}), 64'd0);
    reset = 1'b0;
    ld = 1'b1; tick(); ld = 1'b0;

    // Impulse transform, with start pulses during ISSUE and DRAIN.
    run(1'b1, 0, d);
    chk("done_cycle", 64'(d), 64'd25);
    chk("busy_at_done", 64'(o_busy), 64'd0);
    chk("err_clean", 64'(o_error), 64'd0);
    for (int i = 0; i < N; i++) chk($sformatf("bin%0d", i), 64'(mem[i]), 64'h020000_000000);
    tick();
    chk("done_pulse", 64'({o_done, o_busy}), 64'd0);

    // Reset during stage 1.
    ld = 1'b1; tick(); ld = 1'b0;
    run(1'b0, 11, d);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_mid_flags", 64'({o_busy, o_done, o_error, o_rd_en, o_bf_start, o_wr_en}), 64'd0);
    chk("rst_mid_data", 64'({o_bf_a, o_wr_data_a}), 64'd0);
    wr_seen = 1'b0; err_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      wr_seen  = wr_seen | o_wr_en;
      err_seen = err_seen | o_error;
    end
    chk("no_wr_after_rst", 64'(wr_seen), 64'd0);
    chk("no_err_after_rst", 64'(err_seen), 64'd0);
    ld = 1'b1; tick(); ld = 1'b0;
    run(1'b0, 0, d);
    chk("done_after_rst", 64'(d), 64'd25);
    chk("bin3_after_rst", 64'(mem[3]), 64'h020000_000000);
    chk("bin7_after_rst", 64'(mem[7]), 64'h020000_000000);

    // Spurious butterfly valid while idle.
    tick();
    inj = 1'b1; #1;
    chk("spur_no_wr", 64'(o_wr_en), 64'd0);
    tick(); inj = 1'b0;
    chk("spur_err", 64'(o_error), 64'd1);
    tick();
    chk("err_sticky", 64'(o_error), 64'd1);
    ld = 1'b1; tick(); ld = 1'b0;
    run(1'b0, 1, d);
    chk("err_cleared", 64'(o_error), 64'd0);
    for (int i = 0; i < 40 && !o_done; i++) tick();
    chk("done_after_err", 64'(o_done), 64'd1);

`ifdef FFT_SCHED_INVERSE_EN
    tick();
    i_inverse = 1'b1;
    ld = 1'b1; tick(); ld = 1'b0;
    run(1'b0, 13, d);
    i_inverse = 1'b0;
    chk("inv_tw", 64'(o_bf_twiddle), 64'h000000_400000);
    for (int i = 0; i < 40 && !o_done; i++) tick();
    chk("inv_done", 64'(o_done), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_stage_scheduler.md
# fft_stage_scheduler

In-place radix-2 DIT FFT sequencer that drives the pipelined butterfly unit. It walks all log2(N) stages, reads A/B operand pairs from a dual-port sample RAM, fetches twiddles from a ROM, issues them to the butterfly, and writes the butterfly results back to the same addresses. It sits between the frame buffer (bit-reversed samples already loaded) and the magnitude/readout logic, and signals completion with a done pulse.

## Interface
- FFT_LENGTH, 1024: points N, power of two, 8..65536
- DATA_WIDTH, 24: per-component sample width
- TWIDDLE_WIDTH, 24: per-component twiddle width
- BF_LATENCY, 3: butterfly start-to-valid latency, cycles
- Derived: LOG2N = log2(FFT_LENGTH), ADDR_WIDTH = LOG2N, TW_ADDR_WIDTH = LOG2N-1
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_start  in  1  start pulse; ignored unless idle
- i_inverse  in  1  inverse transform select, sampled with i_start (only with FFT_SCHED_INVERSE_EN)
- o_busy  out  1  high from accepted start until o_done
- o_done  out  1  one-cycle completion pulse
- o_error  out  1  sticky: butterfly valid with no outstanding issue
- o_rd_en  out  1  RAM read strobe, data returned next cycle
- o_rd_addr_a / o_rd_addr_b  out  ADDR_WIDTH  read addresses
- i_rd_data_a / i_rd_data_b  in  2*DATA_WIDTH  {re,im} read data
- o_tw_addr  out  TW_ADDR_WIDTH  twiddle ROM address, 1-cycle latency
- i_tw_data  in  2*TWIDDLE_WIDTH  {re,im} twiddle
- o_bf_start  out  1  butterfly input valid
- o_bf_a / o_bf_b  out  2*DATA_WIDTH  operands (RAM data passed through)
- o_bf_twiddle  out  2*TWIDDLE_WIDTH  twiddle to butterfly
- i_bf_valid  in  1  butterfly result valid
- i_bf_a / i_bf_b  in  2*DATA_WIDTH  results
- o_wr_en  out  1  write strobe (both ports)
- o_wr_addr_a / o_wr_addr_b  out  ADDR_WIDTH  write addresses
- o_wr_data_a / o_wr_data_b  out  2*DATA_WIDTH  write data = i_bf_a / i_bf_b

## Operation
- States: IDLE, ISSUE, DRAIN. IDLE→ISSUE on i_start (stage=0, j=0, o_error cleared). ISSUE: one read per cycle, j increments; at j=N/2-1 → DRAIN. DRAIN: wait until in-flight count = 0; then stage<LOG2N-1 → ISSUE (stage+1, j=0), else → IDLE with o_done.
- Address generation for stage s, butterfly j: half=1<<s, k=j&(half-1); addr_a=((j>>s)<<(s+1))|k; addr_b=addr_a|half; tw_addr=k<<(LOG2N-1-s).
- o_bf_start = o_rd_en delayed 1; operands combinational from RAM data; twiddle from ROM data.
- Write-address tag line: {valid, addr_a, addr_b}, depth 1+BF_LATENCY; on i_bf_valid the oldest tag supplies write addresses. In-flight counter: +1 per read, -1 per write.
- i_bf_valid with zero in-flight: no write, o_error set until next accepted start.
- i_start while busy: ignored, no effect.
- Reset mid-operation: state IDLE, counters and tag line cleared, no further writes; in-flight butterfly results after reset are ignored without setting o_error.

## Timing
- Reset values: all outputs 0.
- Start sampled at cycle 0; first o_rd_en at cycle 1.
- Read at cycle t → o_bf_start at t+1 → o_wr_en at t+1+BF_LATENCY.
- Stage period N/2+BF_LATENCY+1 cycles; next stage's first read the cycle after the previous stage's last write (RAM write visible to a read in the following cycle).
- o_done at cycle 1+LOG2N*(N/2+BF_LATENCY+1) after start; o_busy falls the same cycle. N=8, BF_LATENCY=3: done at cycle 25.
- New start is accepted the cycle after o_done.

## Configuration
- FFT_SCHED_INVERSE_EN defined: i_inverse port present, latched at start; when latched 1, twiddle imaginary part is two's-complement negated before o_bf_twiddle (inverse FFT, same 1/2-per-stage scaling).
- Undefined: port absent, twiddle passed unmodified, forward only.

## Structure
- Shared fft_pkg: state enum, BF_LATENCY default, RAM/ROM read-latency constant, complex pack/unpack helpers.
- Sub-module fft_addr_gen: (stage, j) → addr_a, addr_b, tw_addr, purely combinational.

## Test plan
- N=8 address sequence: stage 0 j=3 → a=6,b=7,tw=0; stage 1 j=3 → a=5,b=7,tw=2; stage 2 j=3 → a=3,b=7,tw=3.
- N=8, impulse x[0]=0x100000 real, behavioural RAM + real butterfly → all 8 bins re=0x020000, im=0; o_done at cycle 25.
- i_start pulsed during ISSUE and DRAIN → ignored; done timing unchanged.
- Reset asserted mid-stage 1 → next cycle all outputs 0, no writes afterwards, o_error stays 0; subsequent start completes normally.
- Spurious i_bf_valid in IDLE → o_error=1, o_wr_en=0; next start clears it.
- With FFT_SCHED_INVERSE_EN, i_inverse=1, ROM tw=(0x000000,0xC00000) → o_bf_twiddle im=0x400000.
